// File: rtl/light_pkg.sv
// Shared definitions for the light-row blocks.
//   light_t        : encoding of a cell light (OFF / RED / GREEN).
//   spawn_state_t  : states of the row source FSM.
//   LFSR_TAPS      : tap mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4).
//   lfsr_next()    : one left shift of that LFSR.
package light_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    OFFER = 2'd2
  } spawn_state_t;

  // Bits 7,5,4,3 are the 1-indexed taps 8,6,5,4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/row_light_spawner_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, shifts left every clock.
// Ports:
//   clock  in  : rising-edge clock
//   reset  in  : asynchronous active-low reset, loads SEED
//   value  out : current LFSR state
// A zero seed would lock the register at zero, so it is replaced by 8'h01.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] value
);
  import light_pkg::*;

  localparam logic [7:0] START = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) value <= START;
    else        value <= lfsr_next(value);
  end

endmodule

// File: rtl/row_light_spawner.sv
// row_light_spawner: source end of a light row. Offers a red or green light
// to the edge cell, waits for the player to capture it, and scores the result.
// Ports:
//   clock         in  : rising-edge clock
//   reset         in  : asynchronous active-low reset
//   enable        in  : 1 = game running
//   edge_light    in  : state of the fed edge cell (00 off, 01 red, 10 green)
//   spawn_light   out : light offered to the edge cell (registered)
//   accepted      out : one-cycle pulse when an offer is captured
//   missed        out : one-cycle pulse when an offer times out
//   accept_count  out : saturating count of captured offers
//   miss_count    out : saturating count of missed offers
//   fsm_state     out : current FSM state (debug)
//
// Offer/capture protocol: spawn_light != 00 is the offer; it is taken on the
// first rising edge where edge_light equals the offered color exactly. Any
// other edge_light value (including the opposite color) leaves the offer up
// until the hold timer expires. A capture on the last hold cycle still counts
// as a capture.
module row_light_spawner #(
  parameter logic [7:0] SEED        = 8'hA5,
  parameter logic [7:0] RED_THRESH  = 8'd128,
  parameter int         GAP_CYCLES  = 4,
  parameter int         HOLD_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] edge_light,
  output logic [1:0] spawn_light,
  output logic       accepted,
  output logic       missed,
  output logic [7:0] accept_count,
  output logic [7:0] miss_count,
  output logic [1:0] fsm_state
);
  import light_pkg::*;

  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  spawn_state_t state;
  light_t       color;
  light_t       pick;
  logic [7:0]   gap_cnt;
  logic [7:0]   hold_cnt;
  logic [7:0]   lfsr_value;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_value)
  );

  assign pick      = (lfsr_value < RED_THRESH) ? RED : GREEN;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      color        <= OFF;
      gap_cnt      <= 8'd0;
      hold_cnt     <= 8'd0;
      spawn_light  <= OFF;
      accepted     <= 1'b0;
      missed       <= 1'b0;
      accept_count <= 8'd0;
      miss_count   <= 8'd0;
    end else begin
      accepted <= 1'b0;
      missed   <= 1'b0;
      if (!enable) begin
        // Pausing withdraws any offer silently: no pulse, counts untouched.
        state       <= IDLE;
        spawn_light <= OFF;
      end else begin
        case (state)
          IDLE: begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
          GAP: begin
            if (gap_cnt != 8'd0) begin
              gap_cnt <= gap_cnt - 8'd1;
            end else if (edge_light == OFF) begin
              // Only spawn into a dark edge cell; otherwise keep waiting.
              state       <= OFFER;
              color       <= pick;
              spawn_light <= pick;
              hold_cnt    <= 8'd0;
            end
          end
          OFFER: begin
            if (edge_light == color) begin
              state       <= GAP;
              gap_cnt     <= GAP_LOAD;
              spawn_light <= OFF;
              accepted    <= 1'b1;
              if (accept_count != 8'hFF) accept_count <= accept_count + 8'd1;
            end else if (hold_cnt == HOLD_LAST) begin
              state       <= GAP;
              gap_cnt     <= GAP_LOAD;
              spawn_light <= OFF;
              missed      <= 1'b1;
              if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          default: begin
            state       <= IDLE;
            spawn_light <= OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_light_spawner.sv
// Self-checking bench for row_light_spawner: a lock-step reference model
// predicts every output each cycle, a table of offer scenarios checks offer
// length and outcome, and hand-written sequences cover gap blocking, pause,
// asynchronous reset and counter saturation.
module tb_row_light_spawner;
  import light_pkg::*;

  localparam logic [7:0] SEED   = 8'hA5;
  localparam logic [7:0] THRESH = 8'd128;
  localparam int         GAP    = 4;
  localparam int         HOLD   = 8;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] edge_light = 2'b00;
  logic [1:0] spawn_light;
  logic       accepted;
  logic       missed;
  logic [7:0] accept_count;
  logic [7:0] miss_count;
  logic [1:0] fsm_state;

  always #5 clock = ~clock;

  row_light_spawner #(
    .SEED(SEED), .RED_THRESH(THRESH), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .edge_light   (edge_light),
    .spawn_light  (spawn_light),
    .accepted     (accepted),
    .missed       (missed),
    .accept_count (accept_count),
    .miss_count   (miss_count),
    .fsm_state    (fsm_state)
  );

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q[$];

  // ---------------- reference model ----------------
  // Game described by elapsed-cycle counts rather than countdown timers:
  // m_run counts edges spent waiting since the last offer/start, m_age counts
  // edges an offer has been up.
  logic [7:0] m_lfsr;
  bit         m_in_game;
  bit         m_offer;
  logic [1:0] m_color;
  int         m_run;
  int         m_age;
  logic       m_acc;
  logic       m_miss;
  logic [7:0] m_acc_cnt;
  logic [7:0] m_miss_cnt;

  function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
    int x;
    int fb;
    x  = int'(v);
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return 8'(((x << 1) | fb) & 255);
  endfunction

  task automatic model_reset();
    m_lfsr     = SEED;
    m_in_game  = 0;
    m_offer    = 0;
    m_color    = 2'b00;
    m_run      = 0;
    m_age      = 0;
    m_acc      = 1'b0;
    m_miss     = 1'b0;
    m_acc_cnt  = 8'd0;
    m_miss_cnt = 8'd0;
  endtask

  task automatic model_advance();
    logic [7:0] pre;
    pre    = m_lfsr;
    m_lfsr = ref_lfsr(m_lfsr);
    m_acc  = 1'b0;
    m_miss = 1'b0;
    if (!enable) begin
      m_in_game = 0;
      m_offer   = 0;
    end else if (!m_in_game) begin
      m_in_game = 1;
      m_offer   = 0;
      m_run     = 0;
    end else if (!m_offer) begin
      m_run = m_run + 1;
      if (m_run >= GAP && edge_light == 2'b00) begin
        m_offer = 1;
        m_age   = 0;
        m_color = (pre < THRESH) ? 2'b01 : 2'b10;
      end
    end else begin
      m_age = m_age + 1;
      if (edge_light == m_color) begin
        m_offer = 0;
        m_run   = 0;
        m_acc   = 1'b1;
        if (m_acc_cnt != 8'd255) m_acc_cnt = m_acc_cnt + 8'd1;
      end else if (m_age >= HOLD) begin
        m_offer = 0;
        m_run   = 0;
        m_miss  = 1'b1;
        if (m_miss_cnt != 8'd255) m_miss_cnt = m_miss_cnt + 8'd1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    logic [19:0] exp;
    logic [19:0] got;
    @(posedge clock);
    if (reset) model_advance();
    else       model_reset();
    exp_q.push_back({(m_offer ? m_color : 2'b00), m_acc, m_miss, m_acc_cnt, m_miss_cnt});
    @(negedge clock);
    got = {spawn_light, accepted, missed, accept_count, miss_count};
    exp = exp_q.pop_front();
    check("cycle {spawn,acc,miss,acnt,mcnt}", 32'(got), 32'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_offer(output int edges);
    bit ok;
    ok    = 0;
    edges = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      edges++;
      if (spawn_light != 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("offer_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int kind;      // 0 none, 1 matching color, 2 opposite color
    int at;        // drive after this many offer cycles have been seen
    int exp_len;   // cycles spawn_light stays on
    bit exp_acc;
    bit exp_miss;
  } vec_t;

  // Starts with the offer visible (first cycle already observed).
  task automatic run_offer(input vec_t v, input int idx);
    int len;
    bit saw_acc;
    bit saw_miss;
    bit done;
    len      = 1;
    saw_acc  = 0;
    saw_miss = 0;
    done     = 0;
    for (int i = 0; i < 300; i++) begin
      if (len == v.at) begin
        if (v.kind == 1)      edge_light = m_color;
        else if (v.kind == 2) edge_light = (m_color == 2'b01) ? 2'b10 : 2'b01;
      end
      step();
      if (accepted) saw_acc = 1;
      if (missed)   saw_miss = 1;
      if (spawn_light == 2'b00) begin
        done = 1;
        break;
      end
      len++;
    end
    edge_light = 2'b00;
    if (!done) check("offer_end_timeout", 32'd0, 32'd1);
    check($sformatf("vec%0d_len", idx), 32'(len), 32'(v.exp_len));
    check($sformatf("vec%0d_acc", idx), 32'(saw_acc), 32'(v.exp_acc));
    check($sformatf("vec%0d_miss", idx), 32'(saw_miss), 32'(v.exp_miss));
  endtask

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int   edges;
    int   r;
    bit   any_on;
    logic [7:0] acc_save;
    logic [7:0] miss_save;

    vecs[0] = '{0, 0, HOLD, 1'b0, 1'b1};  // untouched offer times out
    vecs[1] = '{1, 3, 3,    1'b1, 1'b0};  // capture three cycles in
    vecs[2] = '{2, 1, HOLD, 1'b0, 1'b1};  // opposite color for whole hold
    vecs[3] = '{1, HOLD, HOLD, 1'b1, 1'b0};  // capture on last hold cycle
    vecs[4] = '{1, 1, 1,    1'b1, 1'b0};  // immediate capture
    vecs[5] = '{2, 4, HOLD, 1'b0, 1'b1};  // opposite color late in hold

    model_reset();
    enable = 1'b1;
    repeat (3) step();
    check("reset_spawn", 32'(spawn_light), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));
    check("reset_counts", 32'({accept_count, miss_count}), 32'd0);

    // First offer: one edge leaves IDLE, then GAP edges to the offer.
    reset = 1'b1;
    wait_offer(edges);
    check("first_latency", 32'(edges), 32'(GAP + 1));
    check("first_color", 32'(spawn_light), 32'(2'b01));

    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        wait_offer(edges);
        check($sformatf("vec%0d_gap", i), 32'(edges), 32'(GAP));
      end
      run_offer(vecs[i], i);
      if (i == 0) check("miss_count_first", 32'(miss_count), 32'd1);
    end
    check("acc_count_table", 32'(accept_count), 32'd3);

    // Lit edge cell blocks the next offer until it goes dark.
    edge_light = 2'b10;
    any_on = 0;
    for (int i = 0; i < GAP + 6; i++) begin
      step();
      if (spawn_light != 2'b00) any_on = 1;
    end
    check("held_no_offer", 32'(any_on), 32'd0);
    edge_light = 2'b00;
    step();
    check("offer_after_release", 32'(spawn_light != 2'b00), 32'd1);
    run_offer(vecs[0], 6);

    // Pause mid-offer: withdrawn on the next edge, nothing scored.
    wait_offer(edges);
    repeat (2) step();
    acc_save  = accept_count;
    miss_save = miss_count;
    enable = 1'b0;
    step();
    check("pause_spawn", 32'(spawn_light), 32'd0);
    check("pause_pulses", 32'({accepted, missed}), 32'd0);
    check("pause_counts", 32'({accept_count, miss_count}), 32'({acc_save, miss_save}));
    step();
    enable = 1'b1;
    wait_offer(edges);
    check("reenable_latency", 32'(edges), 32'(GAP + 1));

    // Reset mid-offer clears spawn_light without a clock edge.
    step();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_spawn", 32'(spawn_light), 32'd0);
    check("async_reset_counts", 32'({accept_count, miss_count}), 32'd0);
    model_reset();
    repeat (2) step();
    reset = 1'b1;

    // Accept counter saturates; pulses keep firing.
    for (int i = 0; i < 260; i++) begin
      wait_offer(edges);
      edge_light = m_color;
      step();
      edge_light = 2'b00;
    end
    check("acc_saturate", 32'(accept_count), 32'd255);
    check("acc_pulse_at_sat", 32'(accepted), 32'd1);

    // Miss counter saturates: each miss takes GAP + HOLD cycles.
    repeat ((GAP + HOLD) * 262) step();
    check("miss_saturate", 32'(miss_count), 32'd255);

    // Randomized play against the model.
    reset = 1'b0;
    #1;
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 97);
      r = $urandom_range(0, 99);
      edge_light = (r < 55) ? 2'b00 : ((r < 78) ? 2'b01 : 2'b10);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
